branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Sequences the shared branch comparator for the pipelined core variant.
- Accepts one conditional-branch request at a time from decode and waits until forwarded operands are valid.
- Drives the comparator, compares its outcome with the fetch-time prediction, and issues a redirect/flush on mispredict.
- Sits between decode/forwarding, the branch comparator and the fetch PC mux.

Parameters:
- XLEN, 32, datapath and PC width.
- BHT_ENTRIES, 16, predictor table depth; power of two, minimum 2. Used only with BRANCH_PREDICT_EN.
- BHT_IDX_W, $clog2(BHT_ENTRIES), predictor index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- br_valid  in  1  decode presents a branch.
- br_ready  out  1  controller can accept a branch.
- br_pc  in  XLEN  branch instruction PC.
- br_imm  in  XLEN  sign-extended B-type offset.
- br_funct3  in  3  branch condition.
- br_pred_taken  in  1  prediction used by fetch for this branch.
- ops_valid  in  1  rs1/rs2 values are final (forwarding resolved).
- ops_rs1  in  XLEN  operand 1.
- ops_rs2  in  XLEN  operand 2.
- cmp_rs1  out  XLEN  to comparator.
- cmp_rs2  out  XLEN  to comparator.
- cmp_funct3  out  3  to comparator.
- cmp_taken  in  1  comparator result (combinational from cmp_*).
- resolve_valid  out  1  one-cycle pulse: branch resolved.
- resolve_taken  out  1  actual outcome; qualified by resolve_valid.
- resolve_illegal  out  1  funct3 was 010/011; qualified by resolve_valid.
- redirect_valid  out  1  fetch must be redirected.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  XLEN  corrected PC.
- flush  out  1  kill younger instructions; equals redirect_valid && redirect_ready.
- pred_pc  in  XLEN  fetch lookup PC.
- pred_taken  out  1  combinational prediction for pred_pc.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - All outputs 0 except br_ready = 1.
  - All latched fields cleared.
  - Any in-flight branch is dropped with no resolve and no redirect.
- FSM states: IDLE, WAIT_OPS, EVAL, REDIRECT.
- IDLE:
  - br_ready = 1.
  - On br_valid, latch pc, imm, funct3 and pred_taken.
  - If funct3 is 010 or 011: next state IDLE, and next cycle emit resolve_valid = 1, resolve_illegal = 1, resolve_taken = 0, no redirect.
  - Otherwise, if ops_valid is high in the same cycle: latch the operands, next state EVAL.
  - Otherwise: next state WAIT_OPS.
- WAIT_OPS: br_ready = 0. On ops_valid, latch the operands; next state EVAL.
- EVAL:
  - cmp_* driven from the latched registers; cmp_* are 0 in every other state.
  - Sample cmp_taken at the clock edge.
  - resolve_valid pulses in the cycle after EVAL, with resolve_taken = sampled outcome.
  - If outcome != latched prediction: next state REDIRECT.
  - Otherwise: next state IDLE.
  - Latency, br_valid accept to resolve_valid: 2 cycles with ops_valid at accept; otherwise 1 + wait + 1.
- REDIRECT:
  - redirect_valid = 1.
  - redirect_pc = pc + imm if taken, else pc + 4; modulo 2^XLEN, wrap silently; registered at EVAL exit.
  - Hold until redirect_ready, then go to IDLE. flush is high only in the handshake cycle.
  - br_ready = 0 throughout.
- br_ready = 0 in WAIT_OPS, EVAL and REDIRECT. br_valid is ignored in those states; decode holds it.
- Back-to-back: IDLE accepts a new branch in the same cycle that resolve_valid pulses for the previous one.
- redirect_valid, once high, stays high and redirect_pc stays stable until the handshake.

Optional Feature:
- Macro: BRANCH_PREDICT_EN.
- Defined:
  - Table of BHT_ENTRIES 2-bit saturating counters, indexed by pc[BHT_IDX_W+1:2].
  - Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
  - Reset value 01 for every entry.
  - pred_taken = MSB of the entry indexed by pred_pc.
  - Update on the EVAL edge: increment if taken, decrement if not, saturating. Illegal branches do not update.
  - A lookup of the index being updated in the same cycle returns the old value.
- Undefined: no table, pred_taken tied 0, all other behaviour identical.

Decomposition:
- Shared package holds:
  - Branch funct3 constants: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
  - FSM state typedef.
  - 2-bit counter constants.
- One natural sub-module: branch_bht (counter table with lookup and update ports), instantiated only under BRANCH_PREDICT_EN.

Test Plan:
- BEQ, rs1 = rs2 = 5, pred 0, ops_valid with br_valid, pc 0x100, imm 0x20 -> resolve_taken = 1 at +2 cycles; redirect_pc = 0x120; flush on handshake.
- BNE, rs1 = rs2 = 7, pred 0 -> resolve_taken = 0; no redirect; br_ready back to 1 at +2 cycles.
- BLT, pred 1, ops_valid delayed 3 cycles, rs1 = 0xFFFFFFFF, rs2 = 1 -> taken, no redirect; resolve at accept + 5.
- BGEU, pc 0xFFFFFFFC, actual not-taken, pred 1 -> redirect_pc = 0x00000000 (wrap); redirect_ready held low 4 cycles, redirect_valid and redirect_pc stable throughout.
- funct3 010 -> resolve_illegal = 1, no redirect, no comparator activity; rst_n asserted while in REDIRECT -> all outputs 0 and br_ready = 1 immediately.
- With BRANCH_PREDICT_EN: same pc taken three times -> pred_taken for that pc goes 0, 1, 1 (counter 01→10→11→11); other indices remain 0.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch controller: funct3 encodings, FSM states
// and the 2-bit saturating counter encoding used by the optional predictor.
package branch_ctrl_pkg;

   // Conditional-branch funct3 encodings; 010 and 011 are not branches.
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_OPS = 2'd1,
      ST_EVAL     = 2'd2,
      ST_REDIRECT = 2'd3
   } br_state_e;

   // Counter encoding: MSB is the prediction.
   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   function automatic logic is_branch_f3(input logic [2:0] f3);
      return (f3 == F3_BEQ)  || (f3 == F3_BNE)  || (f3 == F3_BLT) ||
             (f3 == F3_BGE)  || (f3 == F3_BLTU) || (f3 == F3_BGEU);
   endfunction

   // Saturating step towards the observed outcome.
   function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
      if (taken)
         return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
      else
         return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
   endfunction

   function automatic logic cnt_predict(input logic [1:0] cnt);
      return (cnt == CNT_WT) || (cnt == CNT_ST);
   endfunction

endpackage

// File: rtl/branch_ctrl_bht.sv
// Branch history table: BHT_ENTRIES 2-bit saturating counters with a
// combinational lookup port and a single clocked update port. A lookup of
// the entry being updated sees the pre-update value.
module branch_bht
   import branch_ctrl_pkg::*;
#(
   parameter int BHT_ENTRIES = 16,
   parameter int BHT_IDX_W   = $clog2(BHT_ENTRIES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [BHT_IDX_W-1:0] lookup_idx,
   output logic                 lookup_taken,
   input  logic                 upd_en,
   input  logic [BHT_IDX_W-1:0] upd_idx,
   input  logic                 upd_taken
);

   logic [BHT_ENTRIES-1:0] pred_vec;

   genvar gi;
   generate
      for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_entry
         logic [1:0] cnt_q;
         logic [1:0] cnt_d;

         // Step this counter only when the update targets its index.
         always_comb begin
            cnt_d = cnt_q;
            if (upd_en && (upd_idx == BHT_IDX_W'(gi)))
               cnt_d = cnt_next(cnt_q, upd_taken);
         end

         // Counter storage, weak not-taken out of reset.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_q <= CNT_WNT;
            else        cnt_q <= cnt_d;
         end

         assign pred_vec[gi] = cnt_predict(cnt_q);
      end
   endgenerate

   assign lookup_taken = pred_vec[lookup_idx];

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: accepts one conditional branch from decode, waits for
// final operands, drives the shared comparator, reports the outcome and
// redirects fetch on mispredict. Define BRANCH_PREDICT_EN to build the
// 2-bit counter predictor (branch_bht); otherwise pred_taken is tied low.
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 16,
   parameter int BHT_IDX_W   = $clog2(BHT_ENTRIES)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            br_valid,
   output logic            br_ready,
   input  logic [XLEN-1:0] br_pc,
   input  logic [XLEN-1:0] br_imm,
   input  logic [2:0]      br_funct3,
   input  logic            br_pred_taken,
   input  logic            ops_valid,
   input  logic [XLEN-1:0] ops_rs1,
   input  logic [XLEN-1:0] ops_rs2,
   output logic [XLEN-1:0] cmp_rs1,
   output logic [XLEN-1:0] cmp_rs2,
   output logic [2:0]      cmp_funct3,
   input  logic            cmp_taken,
   output logic            resolve_valid,
   output logic            resolve_taken,
   output logic            resolve_illegal,
   output logic            redirect_valid,
   input  logic            redirect_ready,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush,
   input  logic [XLEN-1:0] pred_pc,
   output logic            pred_taken
);

   br_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [XLEN-1:0] rs1_q, rs1_d;
   logic [XLEN-1:0] rs2_q, rs2_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic [2:0]      funct3_q, funct3_d;
   logic            pred_q, pred_d;
   logic            resolve_valid_q, resolve_valid_d;
   logic            resolve_taken_q, resolve_taken_d;
   logic            resolve_illegal_q, resolve_illegal_d;

   logic            mispredict;
   assign mispredict = (cmp_taken != pred_q);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (br_valid && is_branch_f3(br_funct3))
               state_d = ops_valid ? ST_EVAL : ST_WAIT_OPS;
         end
         ST_WAIT_OPS: if (ops_valid)      state_d = ST_EVAL;
         ST_EVAL:     state_d = mispredict ? ST_REDIRECT : ST_IDLE;
         ST_REDIRECT: if (redirect_ready) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Latched branch fields, operands, resolve pulse and redirect target.
   always_comb begin
      pc_d              = pc_q;
      imm_d             = imm_q;
      funct3_d          = funct3_q;
      pred_d            = pred_q;
      rs1_d             = rs1_q;
      rs2_d             = rs2_q;
      redirect_pc_d     = redirect_pc_q;
      resolve_valid_d   = 1'b0;
      resolve_taken_d   = 1'b0;
      resolve_illegal_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (br_valid) begin
               pc_d     = br_pc;
               imm_d    = br_imm;
               funct3_d = br_funct3;
               pred_d   = br_pred_taken;
               if (!is_branch_f3(br_funct3)) begin
                  resolve_valid_d   = 1'b1;
                  resolve_illegal_d = 1'b1;
               end else if (ops_valid) begin
                  rs1_d = ops_rs1;
                  rs2_d = ops_rs2;
               end
            end
         end
         ST_WAIT_OPS: begin
            if (ops_valid) begin
               rs1_d = ops_rs1;
               rs2_d = ops_rs2;
            end
         end
         ST_EVAL: begin
            resolve_valid_d = 1'b1;
            resolve_taken_d = cmp_taken;
            if (mispredict)
               redirect_pc_d = cmp_taken ? (pc_q + imm_q) : (pc_q + XLEN'(4));
         end
         default: ;
      endcase
   end

   // Datapath registers; reset drops any in-flight branch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q              <= '0;
         imm_q             <= '0;
         funct3_q          <= '0;
         pred_q            <= 1'b0;
         rs1_q             <= '0;
         rs2_q             <= '0;
         redirect_pc_q     <= '0;
         resolve_valid_q   <= 1'b0;
         resolve_taken_q   <= 1'b0;
         resolve_illegal_q <= 1'b0;
      end else begin
         pc_q              <= pc_d;
         imm_q             <= imm_d;
         funct3_q          <= funct3_d;
         pred_q            <= pred_d;
         rs1_q             <= rs1_d;
         rs2_q             <= rs2_d;
         redirect_pc_q     <= redirect_pc_d;
         resolve_valid_q   <= resolve_valid_d;
         resolve_taken_q   <= resolve_taken_d;
         resolve_illegal_q <= resolve_illegal_d;
      end
   end

   // Outputs decoded from state; comparator inputs are quiet outside EVAL.
   always_comb begin
      br_ready       = (state_q == ST_IDLE);
      redirect_valid = (state_q == ST_REDIRECT);
      redirect_pc    = redirect_valid ? redirect_pc_q : '0;
      flush          = redirect_valid && redirect_ready;
      cmp_rs1        = '0;
      cmp_rs2        = '0;
      cmp_funct3     = '0;
      if (state_q == ST_EVAL) begin
         cmp_rs1    = rs1_q;
         cmp_rs2    = rs2_q;
         cmp_funct3 = funct3_q;
      end
   end

   assign resolve_valid   = resolve_valid_q;
   assign resolve_taken   = resolve_taken_q;
   assign resolve_illegal = resolve_illegal_q;

   // Keeps configuration-dependent inputs and parameters referenced.
   logic                             unused_pred_pc;
   logic [BHT_ENTRIES+BHT_IDX_W-1:0] unused_bht_cfg;
   assign unused_pred_pc = ^pred_pc;
   assign unused_bht_cfg = '0;

`ifdef BRANCH_PREDICT_EN
   branch_bht #(
      .BHT_ENTRIES (BHT_ENTRIES),
      .BHT_IDX_W   (BHT_IDX_W)
   ) u_bht (
      .clk          (clk),
      .rst_n        (rst_n),
      .lookup_idx   (pred_pc[BHT_IDX_W+1:2]),
      .lookup_taken (pred_taken),
      .upd_en       (state_q == ST_EVAL),
      .upd_idx      (pc_q[BHT_IDX_W+1:2]),
      .upd_taken    (cmp_taken)
   );
`else
   assign pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: table of branch transactions plus
// hand-written sequences for reset-in-REDIRECT and the optional predictor.
module tb_branch_ctrl;
   import branch_ctrl_pkg::*;

   localparam int XLEN = 32;

   logic            clk, rst_n;
   logic            br_valid, br_ready, br_pred_taken;
   logic [XLEN-1:0] br_pc, br_imm;
   logic [2:0]      br_funct3;
   logic            ops_valid;
   logic [XLEN-1:0] ops_rs1, ops_rs2;
   logic [XLEN-1:0] cmp_rs1, cmp_rs2;
   logic [2:0]      cmp_funct3;
   logic            cmp_taken;
   logic            resolve_valid, resolve_taken, resolve_illegal;
   logic            redirect_valid, redirect_ready, flush;
   logic [XLEN-1:0] redirect_pc, pred_pc;
   logic            pred_taken;

   branch_ctrl #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .br_valid(br_valid), .br_ready(br_ready), .br_pc(br_pc), .br_imm(br_imm),
      .br_funct3(br_funct3), .br_pred_taken(br_pred_taken),
      .ops_valid(ops_valid), .ops_rs1(ops_rs1), .ops_rs2(ops_rs2),
      .cmp_rs1(cmp_rs1), .cmp_rs2(cmp_rs2), .cmp_funct3(cmp_funct3),
      .cmp_taken(cmp_taken),
      .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
      .resolve_illegal(resolve_illegal),
      .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
      .redirect_pc(redirect_pc), .flush(flush),
      .pred_pc(pred_pc), .pred_taken(pred_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural branch comparator standing in for the shared unit.
   always_comb begin
      cmp_taken = 1'b0;
      case (cmp_funct3)
         F3_BEQ:  cmp_taken = (cmp_rs1 == cmp_rs2);
         F3_BNE:  cmp_taken = (cmp_rs1 != cmp_rs2);
         F3_BLT:  cmp_taken = ($signed(cmp_rs1) <  $signed(cmp_rs2));
         F3_BGE:  cmp_taken = ($signed(cmp_rs1) >= $signed(cmp_rs2));
         F3_BLTU: cmp_taken = (cmp_rs1 <  cmp_rs2);
         F3_BGEU: cmp_taken = (cmp_rs1 >= cmp_rs2);
         default: cmp_taken = 1'b0;
      endcase
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [2:0]  f3;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        pred;
      logic [3:0]  delay;     // cycles after accept before ops_valid
      logic        exp_taken;
      logic        exp_ill;
      logic        exp_redir;
      logic [31:0] exp_rpc;
      logic [3:0]  hold;      // cycles redirect_ready stays low
   } vec_t;

   vec_t vecs [10];

   // Issue one branch starting at a negedge with the DUT idle; returns at a
   // negedge with the DUT idle again.
   task automatic run_branch(input vec_t v);
      int lat_exp;
      int lat_got;
      int d;
      d = int'(v.delay);
      check("br_ready_pre", 32'(br_ready), 32'd1);
      br_valid      = 1'b1;
      br_pc         = v.pc;
      br_imm        = v.imm;
      br_funct3     = v.f3;
      br_pred_taken = v.pred;
      ops_rs1       = v.rs1;
      ops_rs2       = v.rs2;
      ops_valid     = (d == 0);
      lat_exp = v.exp_ill ? 1 : d + 2;
      lat_got = 0;
      for (int n = 1; n <= 20 && lat_got == 0; n++) begin
         @(posedge clk);
         @(negedge clk);
         br_valid  = 1'b0;
         ops_valid = (!v.exp_ill && d != 0 && n == d);
         if (!v.exp_ill && n == d + 1) begin
            check("cmp_rs1", cmp_rs1, v.rs1);
            check("cmp_rs2", cmp_rs2, v.rs2);
            check("cmp_funct3", 32'(cmp_funct3), 32'(v.f3));
         end
         if (v.exp_ill && n == 1)
            check("cmp_idle_illegal", cmp_rs1 | cmp_rs2 | 32'(cmp_funct3), 32'd0);
         if (resolve_valid) lat_got = n;
      end
      check("latency", 32'(lat_got), 32'(lat_exp));
      check("resolve_taken", 32'(resolve_taken), 32'(v.exp_taken));
      check("resolve_illegal", 32'(resolve_illegal), 32'(v.exp_ill));
      if (v.exp_redir) begin
         check("redirect_valid", 32'(redirect_valid), 32'd1);
         check("redirect_pc", redirect_pc, v.exp_rpc);
         check("br_ready_redir", 32'(br_ready), 32'd0);
         for (int h = 0; h < int'(v.hold); h++) begin
            check("flush_early", 32'(flush), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("redirect_valid_hold", 32'(redirect_valid), 32'd1);
            check("redirect_pc_hold", redirect_pc, v.exp_rpc);
         end
         redirect_ready = 1'b1;
         #1;
         check("flush", 32'(flush), 32'd1);
         @(posedge clk);
         @(negedge clk);
         redirect_ready = 1'b0;
         check("redirect_done", 32'(redirect_valid), 32'd0);
         check("br_ready_post", 32'(br_ready), 32'd1);
      end else begin
         check("no_redirect", 32'(redirect_valid), 32'd0);
         check("br_ready_b2b", 32'(br_ready), 32'd1);
      end
      $display("branch f3=%03b pc=%08h pred=%0d lat=%0d taken=%0d ill=%0d redir=%0d rpc=%08h",
               v.f3, v.pc, v.pred, lat_got, resolve_taken, resolve_illegal, v.exp_redir, v.exp_rpc);
   endtask

   initial begin
      //             f3      pc            imm           rs1           rs2           pr  dly  t  il rd  rpc           hold
      vecs[0] = '{3'b000, 32'h0000_0100, 32'h0000_0020, 32'd5,        32'd5,        1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0120, 4'd0};
      vecs[1] = '{3'b001, 32'h0000_0200, 32'h0000_0040, 32'd7,        32'd7,        1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0,         4'd0};
      vecs[2] = '{3'b100, 32'h0000_0300, 32'h0000_0010, 32'hFFFF_FFFF, 32'd1,       1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 32'h0,         4'd0};
      vecs[3] = '{3'b111, 32'hFFFF_FFFC, 32'h0000_0008, 32'd1,        32'd2,        1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 4'd4};
      vecs[4] = '{3'b010, 32'h0000_0400, 32'h0000_0008, 32'd0,        32'd0,        1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0};
      vecs[5] = '{3'b101, 32'h0000_0440, 32'h0000_0010, 32'h8000_0000, 32'd0,       1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 32'h0,         4'd0};
      vecs[6] = '{3'b110, 32'h0000_0500, 32'hFFFF_FFF0, 32'd1,        32'hFFFF_FFFF, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 32'h0000_04F0, 4'd1};
      vecs[7] = '{3'b001, 32'h0000_0520, 32'h0000_0008, 32'd3,        32'd4,        1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 32'h0,         4'd0};
      vecs[8] = '{3'b011, 32'h0000_0540, 32'h0000_0008, 32'd1,        32'd1,        1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0,         4'd0};
      vecs[9] = '{3'b000, 32'h0000_0560, 32'h0000_0100, 32'd9,        32'd8,        1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0564, 4'd0};

      rst_n = 1'b0; br_valid = 1'b0; br_pc = '0; br_imm = '0; br_funct3 = '0;
      br_pred_taken = 1'b0; ops_valid = 1'b0; ops_rs1 = '0; ops_rs2 = '0;
      redirect_ready = 1'b0; pred_pc = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_br_ready", 32'(br_ready), 32'd1);
      check("rst_resolve_valid", 32'(resolve_valid), 32'd0);
      check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_cmp", cmp_rs1 | cmp_rs2 | 32'(cmp_funct3), 32'd0);
      check("rst_pred_taken", 32'(pred_taken), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);

      for (int i = 0; i < 10; i++) run_branch(vecs[i]);

      // Reset while a redirect is pending: everything clears immediately.
      br_valid = 1'b1; br_pc = 32'h100; br_imm = 32'h20; br_funct3 = F3_BEQ;
      br_pred_taken = 1'b0; ops_rs1 = 32'd5; ops_rs2 = 32'd5; ops_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      br_valid = 1'b0; ops_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("pre_reset_redirect", 32'(redirect_valid), 32'd1);
      redirect_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      check("async_br_ready", 32'(br_ready), 32'd1);
      check("async_redirect_valid", 32'(redirect_valid), 32'd0);
      check("async_redirect_pc", redirect_pc, 32'd0);
      check("async_flush", 32'(flush), 32'd0);
      check("async_resolve", 32'({resolve_valid, resolve_taken, resolve_illegal}), 32'd0);
      @(posedge clk);
      @(negedge clk);
      redirect_ready = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_reset_idle", 32'({br_ready, redirect_valid, resolve_valid}), 32'b100);
      $display("reset during REDIRECT: br_ready=%0d redirect_valid=%0d", br_ready, redirect_valid);

`ifdef BRANCH_PREDICT_EN
      // Same pc taken three times: counter 01 -> 10 -> 11 -> 11.
      pred_pc = 32'h604;
      #1;
      check("bht_init", 32'(pred_taken), 32'd0);
      for (int k = 0; k < 3; k++) begin
         run_branch('{3'b000, 32'h604, 32'h20, 32'd1, 32'd1, 1'b1, 4'd0,
                      1'b1, 1'b0, 1'b0, 32'h0, 4'd0});
         pred_pc = 32'h604;
         #1;
         check("bht_trained", 32'(pred_taken), 32'd1);
         pred_pc = 32'h608;
         #1;
         check("bht_other_idx", 32'(pred_taken), 32'd0);
      end
`else
      for (int k = 0; k < 3; k++) begin
         pred_pc = 32'h100 << k;
         #1;
         check("pred_tied_low", 32'(pred_taken), 32'd0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1);
   end

endmodule
